// File: rtl/banked_input_buffer.sv
// banked_input_buffer: operand row-vector SRAM for the systolic array.
// One lane-masked host write port, NUM_RD_PORTS registered read ports, an
// optional ping-pong bank pair (host fills shadow, readers see active) and
// per-read int8 sign extension applied ahead of the output register.
module banked_input_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int LANES        = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int NUM_RD_PORTS = 3,
    parameter int PING_PONG    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         host_wr_en,
    input  logic [ADDR_WIDTH-1:0]        host_wr_addr,
    input  logic [LANES-1:0]             host_wr_lane_en,
    input  logic [DATA_WIDTH-1:0]        host_wr_data [LANES],
    input  logic                         swap_req,
    output logic                         swap_ack,
    output logic                         active_bank,
    input  logic [NUM_RD_PORTS-1:0]      rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr [NUM_RD_PORTS],
    input  logic [NUM_RD_PORTS-1:0]      rd_sext8,
    output logic [NUM_RD_PORTS-1:0]      rd_valid,
    output logic signed [DATA_WIDTH-1:0] rd_data [NUM_RD_PORTS][LANES]
);

    localparam bit PP        = (PING_PONG != 0);
    // With ping-pong the bank number becomes the top address bit of one flat array.
    localparam int MEM_AW    = ADDR_WIDTH + (PP ? 1 : 0);
    localparam int MEM_DEPTH = 1 << MEM_AW;

    logic [DATA_WIDTH-1:0]        r_mem [MEM_DEPTH][LANES];
    logic                         r_active_bank;
    logic                         r_swap_ack;
    logic [NUM_RD_PORTS-1:0]      r_rd_valid;
    logic signed [DATA_WIDTH-1:0] r_rd_data [NUM_RD_PORTS][LANES];

    logic                         w_swap;
    logic [MEM_AW-1:0]            w_wr_mem_addr;
    logic [MEM_AW-1:0]            w_rd_mem_addr [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0]        w_rd_lane [NUM_RD_PORTS][LANES];
    logic [DATA_WIDTH-1:0]        w_rd_ext  [NUM_RD_PORTS][LANES];

    // Swap requests are meaningless without a second bank.
    assign w_swap = swap_req & PP;

    generate
        if (PP) begin : g_pp
            // Host always targets the shadow bank, readers the active one.
            assign w_wr_mem_addr = {~r_active_bank, host_wr_addr};
            for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
                assign w_rd_mem_addr[p] = {r_active_bank, rd_addr[p]};
            end
        end else begin : g_sb
            assign w_wr_mem_addr = host_wr_addr;
            for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
                assign w_rd_mem_addr[p] = rd_addr[p];
            end
        end
    endgenerate

    // Storage write: only enabled lanes are updated; contents are never reset.
    always_ff @(posedge clk) begin
        if (host_wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (host_wr_lane_en[l]) begin
                    r_mem[w_wr_mem_addr][l] <= host_wr_data[l];
                end
            end
        end
    end

    // Array lookup with write-first bypass; only a single bank can collide.
    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            for (int l = 0; l < LANES; l++) begin
                w_rd_lane[p][l] = r_mem[w_rd_mem_addr[p]][l];
                if (!PP && host_wr_en && host_wr_lane_en[l] &&
                    (host_wr_addr == rd_addr[p])) begin
                    w_rd_lane[p][l] = host_wr_data[l];
                end
            end
        end
    end

    // Optional int8 sign extension, folded in before the output register.
    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            for (int l = 0; l < LANES; l++) begin
                w_rd_ext[p][l] = w_rd_lane[p][l];
                if (rd_sext8[p]) begin
                    w_rd_ext[p][l] = {{(DATA_WIDTH-8){w_rd_lane[p][l][7]}},
                                      w_rd_lane[p][l][7:0]};
                end
            end
        end
    end

    // Read output registers: data only loads on a strobe so idle ports hold steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= '0;
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                for (int l = 0; l < LANES; l++) begin
                    r_rd_data[p][l] <= '0;
                end
            end
        end else begin
            r_rd_valid <= rd_en;
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                if (rd_en[p]) begin
                    for (int l = 0; l < LANES; l++) begin
                        r_rd_data[p][l] <= w_rd_ext[p][l];
                    end
                end
            end
        end
    end

    // Bank select toggles on each request; the ack is visible alongside the new bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_bank <= 1'b0;
            r_swap_ack    <= 1'b0;
        end else begin
            r_active_bank <= r_active_bank ^ w_swap;
            r_swap_ack    <= w_swap;
        end
    end

    assign active_bank = r_active_bank;
    assign swap_ack    = r_swap_ack;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_banked_input_buffer.sv
// Directed bench for banked_input_buffer: a ping-pong instance and a
// single-bank instance share all inputs; each test checks the relevant one.
module tb_banked_input_buffer;

    logic               clk;
    logic               rst_n;
    logic               host_wr_en;
    logic [9:0]         host_wr_addr;
    logic [15:0]        host_wr_lane_en;
    logic [31:0]        host_wr_data [16];
    logic               swap_req;
    logic [2:0]         rd_en;
    logic [9:0]         rd_addr [3];
    logic [2:0]         rd_sext8;

    logic               pp_swap_ack, pp_active_bank;
    logic [2:0]         pp_rd_valid;
    logic signed [31:0] pp_rd_data [3][16];
    logic               sb_swap_ack, sb_active_bank;
    logic [2:0]         sb_rd_valid;
    logic signed [31:0] sb_rd_data [3][16];

    int n_checks = 0;
    int n_errors = 0;

    banked_input_buffer #(.PING_PONG(1)) u_dut_pp (
        .clk(clk), .rst_n(rst_n),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr),
        .host_wr_lane_en(host_wr_lane_en), .host_wr_data(host_wr_data),
        .swap_req(swap_req), .swap_ack(pp_swap_ack), .active_bank(pp_active_bank),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_sext8(rd_sext8),
        .rd_valid(pp_rd_valid), .rd_data(pp_rd_data)
    );

    banked_input_buffer #(.PING_PONG(0)) u_dut_sb (
        .clk(clk), .rst_n(rst_n),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr),
        .host_wr_lane_en(host_wr_lane_en), .host_wr_data(host_wr_data),
        .swap_req(swap_req), .swap_ack(sb_swap_ack), .active_bank(sb_active_bank),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_sext8(rd_sext8),
        .rd_valid(sb_rd_valid), .rd_data(sb_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input logic [9:0] addr, input logic [15:0] mask,
                           input logic [31:0] base, input logic [31:0] step);
        host_wr_en      = 1'b1;
        host_wr_addr    = addr;
        host_wr_lane_en = mask;
        for (int i = 0; i < 16; i++) host_wr_data[i] = base + step * i;
    endtask

    task automatic wr_row(input logic [9:0] addr, input logic [15:0] mask,
                          input logic [31:0] base, input logic [31:0] step);
        set_row(addr, mask, base, step);
        tick();
        host_wr_en = 1'b0;
    endtask

    task automatic rd(input int p, input logic [9:0] addr, input logic sext);
        rd_en[p]    = 1'b1;
        rd_addr[p]  = addr;
        rd_sext8[p] = sext;
    endtask

    initial begin
        rst_n           = 1'b0;
        host_wr_en      = 1'b0;
        host_wr_addr    = '0;
        host_wr_lane_en = '0;
        for (int i = 0; i < 16; i++) host_wr_data[i] = '0;
        swap_req        = 1'b0;
        rd_en           = '0;
        rd_sext8        = '0;
        for (int p = 0; p < 3; p++) rd_addr[p] = '0;

        #12;
        check("rst_valid",  {29'b0, pp_rd_valid}, 32'd0);
        check("rst_data",   pp_rd_data[0][0], 32'd0);
        check("rst_bank",   pp_active_bank, 32'd0);
        check("rst_ack",    pp_swap_ack, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: full-row write then latency-1 read on port 0 (single bank)
        wr_row(10'd5, 16'hFFFF, 32'd1, 32'd1);
        rd(0, 10'd5, 1'b0);
        tick();
        rd_en = '0;
        check("t1_valid", sb_rd_valid[0], 32'd1);
        for (int i = 0; i < 16; i++) check($sformatf("t1_lane%0d", i), sb_rd_data[0][i], i + 1);
        tick();
        check("t1_valid_drop", sb_rd_valid[0], 32'd0);
        check("t1_hold", sb_rd_data[0][3], 32'd4);

        // 2: lane-masked overwrite
        wr_row(10'd7, 16'hFFFF, 32'hAAAA_AAAA, 32'd0);
        wr_row(10'd7, 16'h0003, 32'h11, 32'd0);
        rd(2, 10'd7, 1'b0);
        tick();
        rd_en = '0;
        check("t2_lane0",  sb_rd_data[2][0],  32'h11);
        check("t2_lane1",  sb_rd_data[2][1],  32'h11);
        check("t2_lane2",  sb_rd_data[2][2],  32'hAAAA_AAAA);
        check("t2_lane15", sb_rd_data[2][15], 32'hAAAA_AAAA);

        // 3: int8 sign extension on/off
        wr_row(10'd9, 16'h0001, 32'h0000_00F0, 32'd0);
        rd(1, 10'd9, 1'b1);
        tick();
        check("t3_sext", sb_rd_data[1][0], 32'hFFFF_FFF0);
        rd(1, 10'd9, 1'b0);
        tick();
        rd_en = '0;
        check("t3_raw", sb_rd_data[1][0], 32'h0000_00F0);

        // 5: single-bank write-first, all ports agree
        wr_row(10'd3, 16'hFFFF, 32'h10, 32'd0);
        set_row(10'd3, 16'h0001, 32'h99, 32'd0);
        for (int p = 0; p < 3; p++) rd(p, 10'd3, 1'b0);
        tick();
        host_wr_en = 1'b0;
        rd_en      = '0;
        for (int p = 0; p < 3; p++) begin
            check($sformatf("t5_p%0d_lane0", p), sb_rd_data[p][0], 32'h99);
            check($sformatf("t5_p%0d_lane1", p), sb_rd_data[p][1], 32'h10);
        end
        rd(0, 10'd3, 1'b0);
        tick();
        rd_en = '0;
        check("t5_stored_lane0", sb_rd_data[0][0], 32'h99);
        check("t5_stored_lane5", sb_rd_data[0][5], 32'h10);

        // 4: ping-pong; first place 0x22 in bank 0 row 0
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("t4_ack_a",  pp_swap_ack, 32'd1);
        check("t4_bank_a", pp_active_bank, 32'd1);
        check("sb_ack",    sb_swap_ack, 32'd0);
        check("sb_bank",   sb_active_bank, 32'd0);
        wr_row(10'd0, 16'hFFFF, 32'h22, 32'd0);
        check("t4_ack_once", pp_swap_ack, 32'd0);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("t4_bank_b", pp_active_bank, 32'd0);
        set_row(10'd0, 16'hFFFF, 32'h55, 32'd0);
        rd(1, 10'd0, 1'b0);
        tick();
        host_wr_en = 1'b0;
        rd_en      = '0;
        check("t4_active_l0",  pp_rd_data[1][0],  32'h22);
        check("t4_active_l15", pp_rd_data[1][15], 32'h22);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("t4_ack_c",  pp_swap_ack, 32'd1);
        check("t4_bank_c", pp_active_bank, 32'd1);
        rd(1, 10'd0, 1'b0);
        tick();
        rd_en = '0;
        check("t4_ack_c_end", pp_swap_ack, 32'd0);
        check("t4_after_swap", pp_rd_data[1][0], 32'h55);

        // read and write on the swap edge use the pre-swap mapping
        swap_req = 1'b1;
        rd(0, 10'd0, 1'b0);
        set_row(10'd1, 16'hFFFF, 32'h77, 32'd0);
        tick();
        swap_req   = 1'b0;
        rd_en      = '0;
        host_wr_en = 1'b0;
        check("swap_edge_rd",   pp_rd_data[0][0], 32'h55);
        check("swap_edge_bank", pp_active_bank, 32'd0);
        rd(2, 10'd1, 1'b0);
        tick();
        rd_en = '0;
        check("swap_edge_wr", pp_rd_data[2][7], 32'h77);

        // back-to-back swap requests
        swap_req = 1'b1;
        tick();
        check("b2b_ack1",  pp_swap_ack, 32'd1);
        check("b2b_bank1", pp_active_bank, 32'd1);
        tick();
        swap_req = 1'b0;
        check("b2b_ack2",  pp_swap_ack, 32'd1);
        check("b2b_bank2", pp_active_bank, 32'd0);
        tick();
        check("b2b_ack3",  pp_swap_ack, 32'd0);
        check("b2b_bank3", pp_active_bank, 32'd0);

        // 6: asynchronous reset mid-read
        swap_req = 1'b1;
        rd(0, 10'd0, 1'b0);
        tick();
        swap_req = 1'b0;
        rd_en    = '0;
        check("t6_pre_valid", pp_rd_valid[0], 32'd1);
        check("t6_pre_bank",  pp_active_bank, 32'd1);
        check("t6_pre_ack",   pp_swap_ack, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_valid", {29'b0, pp_rd_valid}, 32'd0);
        check("t6_bank",  pp_active_bank, 32'd0);
        check("t6_ack",   pp_swap_ack, 32'd0);
        check("t6_data",  pp_rd_data[0][0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_post_valid", pp_rd_valid[0], 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
